// File: rtl/rv32_barrel_mvu_jobq_pkg.sv
// Shared CSR addresses, op encoding and MVU_STATUS bit positions for the
// barrel-core MVU job queue.
package pito_pkg;

  localparam logic [11:0] CSR_MVU_CFG_BASE = 12'hF20;
  localparam logic [11:0] CSR_MVU_CMD      = 12'hF40;
  localparam logic [11:0] CSR_MVU_STATUS   = 12'hF41;
  localparam logic [11:0] CSR_MVU_PERF     = 12'hF42;

  typedef enum logic [2:0] {
    CSR_OP_NONE  = 3'd0,
    CSR_OP_WRITE = 3'd1,
    CSR_OP_SET   = 3'd2,
    CSR_OP_CLEAR = 3'd3,
    CSR_OP_READ  = 3'd4
  } csr_op_e;

  localparam int unsigned STATUS_BUSY    = 0;
  localparam int unsigned STATUS_DONE    = 1;
  localparam int unsigned STATUS_OVF     = 2;
  localparam int unsigned STATUS_IRQ_EN  = 3;
  localparam int unsigned STATUS_CNT_LSB = 8;
  localparam int unsigned STATUS_CNT_MSB = 15;

endpackage

// File: rtl/rv32_barrel_mvu_jobq_fifo.sv
// Single-hart job FIFO: QDEPTH entries of NUM_CFG 32-bit words, head exposed
// combinationally, pointers wrap modulo QDEPTH.
module rv32_mvu_job_fifo
  import pito_pkg::*;
#(
  parameter int unsigned NUM_CFG = 26,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [NUM_CFG*32-1:0]         push_data,
  input  logic                          pop,
  output logic [NUM_CFG*32-1:0]         head,
  output logic [$clog2(QDEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [NUM_CFG*32-1:0] mem [QDEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < QDEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rv32_barrel_mvu_jobq.sv
// Per-hart MVU job-descriptor CSR bank with job FIFO, handshake and done irq.
// Optional busy-cycle counter at 0xF42 is enabled with `define MVU_JOBQ_PERF_EN.
module rv32_barrel_mvu_jobq
  import pito_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 8,
  parameter int unsigned NUM_CFG   = 26,
  parameter int unsigned QDEPTH    = 2,
  parameter int unsigned HART_W    = $clog2(NUM_HARTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [HART_W-1:0]               hart_id_i,
  input  logic [11:0]                     csr_addr_i,
  input  logic [2:0]                      csr_op_i,
  input  logic [31:0]                     csr_wdata_i,
  output logic [31:0]                     csr_rdata_o,
  output logic                            csr_illegal_o,
  output logic [NUM_HARTS-1:0]            mvu_job_valid_o,
  input  logic [NUM_HARTS-1:0]            mvu_job_ready_i,
  output logic [NUM_HARTS*NUM_CFG*32-1:0] mvu_job_cfg_o,
  input  logic [NUM_HARTS-1:0]            mvu_done_i,
  output logic [NUM_HARTS-1:0]            mvu_irq_o
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned CFG_W = $clog2(NUM_CFG);
  localparam int unsigned JOB_W = NUM_CFG * 32;
  localparam logic [31:0] RO_MASK = (32'hFF << STATUS_CNT_LSB) | (32'h1 << STATUS_BUSY);

  csr_op_e op;
  assign op = csr_op_e'(csr_op_i);

  logic [31:0]          stg [NUM_HARTS][NUM_CFG];
  logic [NUM_HARTS-1:0] busy, done_st, ovf, irq_en, push, pop;
  logic [CNT_W-1:0]     cnt  [NUM_HARTS];
  logic [JOB_W-1:0]     head [NUM_HARTS];
  logic [JOB_W-1:0]     snap;

  logic [11:0]      cfg_off;
  logic [CFG_W-1:0] cfg_idx;
  logic             acc_op, mod_op, in_rng, is_cfg, is_cmd, is_stat, is_perf;
  logic             ro_viol, illegal, commit, w1c_op;
  logic [31:0]      cfg_cur, cfg_new, stat_cur, stat_mod, rd_val;

`ifdef MVU_JOBQ_PERF_EN
  logic [31:0] perf [NUM_HARTS];
`endif

  always_comb begin
    acc_op  = op inside {CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR, CSR_OP_READ};
    mod_op  = op inside {CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR};
    cfg_off = csr_addr_i - CSR_MVU_CFG_BASE;
    cfg_idx = cfg_off[CFG_W-1:0];
    in_rng  = (csr_addr_i >= CSR_MVU_CFG_BASE) && (csr_addr_i <= CSR_MVU_PERF);
    is_cfg  = in_rng && (cfg_off < 12'(NUM_CFG));
    is_cmd  = csr_addr_i == CSR_MVU_CMD;
    is_stat = csr_addr_i == CSR_MVU_STATUS;
`ifdef MVU_JOBQ_PERF_EN
    is_perf = csr_addr_i == CSR_MVU_PERF;
`else
    is_perf = 1'b0;
`endif

    cfg_cur = is_cfg ? stg[hart_id_i][cfg_idx] : '0;
    case (op)
      CSR_OP_WRITE: cfg_new = csr_wdata_i;
      CSR_OP_SET:   cfg_new = cfg_cur | csr_wdata_i;
      CSR_OP_CLEAR: cfg_new = cfg_cur & ~csr_wdata_i;
      default:      cfg_new = cfg_cur;
    endcase

    stat_cur = '0;
    stat_cur[STATUS_BUSY]   = busy[hart_id_i];
    stat_cur[STATUS_DONE]   = done_st[hart_id_i];
    stat_cur[STATUS_OVF]    = ovf[hart_id_i];
    stat_cur[STATUS_IRQ_EN] = irq_en[hart_id_i];
    stat_cur[STATUS_CNT_MSB:STATUS_CNT_LSB] = 8'(cnt[hart_id_i]);
    case (op)
      CSR_OP_WRITE: stat_mod = csr_wdata_i;
      CSR_OP_SET:   stat_mod = stat_cur | csr_wdata_i;
      CSR_OP_CLEAR: stat_mod = stat_cur & ~csr_wdata_i;
      default:      stat_mod = stat_cur;
    endcase
    // RO violation means the op would change busy/count; the other fields still apply
    ro_viol = is_stat && mod_op && (((stat_mod ^ stat_cur) & RO_MASK) != '0);
    illegal = !rst && acc_op && in_rng &&
              (!(is_cfg || is_cmd || is_stat || is_perf) || ro_viol);
    w1c_op  = is_stat && (op inside {CSR_OP_WRITE, CSR_OP_SET});
    commit  = is_cmd && (op inside {CSR_OP_WRITE, CSR_OP_SET}) && csr_wdata_i[0];

    rd_val = '0;
    if (is_cfg)       rd_val = cfg_cur;
    else if (is_stat) rd_val = stat_cur;
`ifdef MVU_JOBQ_PERF_EN
    else if (is_perf) rd_val = perf[hart_id_i];
`endif
    csr_rdata_o   = (op == CSR_OP_READ && !illegal) ? rd_val : '0;
    csr_illegal_o = illegal;

    for (int unsigned i = 0; i < NUM_CFG; i++) snap[i*32 +: 32] = stg[hart_id_i][i];
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    assign push[h] = commit && (hart_id_i == HART_W'(h)) && (cnt[h] < CNT_W'(QDEPTH));
    assign mvu_job_valid_o[h] = (cnt[h] != '0) && !busy[h];
    assign pop[h]       = mvu_job_valid_o[h] && mvu_job_ready_i[h];
    assign mvu_irq_o[h] = done_st[h] && irq_en[h];
    assign mvu_job_cfg_o[h*JOB_W +: JOB_W] = head[h];

    rv32_mvu_job_fifo #(
      .NUM_CFG (NUM_CFG),
      .QDEPTH  (QDEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[h]),
      .push_data (snap),
      .pop       (pop[h]),
      .head      (head[h]),
      .count     (cnt[h])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++)
        for (int unsigned i = 0; i < NUM_CFG; i++) stg[h][i] <= '0;
      busy    <= '0;
      done_st <= '0;
      ovf     <= '0;
      irq_en  <= '0;
    end else begin
      if (is_cfg && mod_op) stg[hart_id_i][cfg_idx] <= cfg_new;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (pop[h])                       busy[h] <= 1'b1;
        else if (mvu_done_i[h] && busy[h]) busy[h] <= 1'b0;

        // a completion arriving with a W1C wins so the event is never lost
        if (mvu_done_i[h] && busy[h])
          done_st[h] <= 1'b1;
        else if (w1c_op && hart_id_i == HART_W'(h) && csr_wdata_i[STATUS_DONE])
          done_st[h] <= 1'b0;

        if (commit && hart_id_i == HART_W'(h) && cnt[h] == CNT_W'(QDEPTH))
          ovf[h] <= 1'b1;
        else if (w1c_op && hart_id_i == HART_W'(h) && csr_wdata_i[STATUS_OVF])
          ovf[h] <= 1'b0;

        if (is_stat && mod_op && hart_id_i == HART_W'(h))
          irq_en[h] <= stat_mod[STATUS_IRQ_EN];
      end
    end
  end

`ifdef MVU_JOBQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) perf[h] <= '0;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (is_perf && mod_op && hart_id_i == HART_W'(h)) perf[h] <= '0;
        else if (busy[h])                                 perf[h] <= perf[h] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rv32_barrel_mvu_jobq.sv
// Directed bench for rv32_barrel_mvu_jobq; covers the 0xF42 counter when
// MVU_JOBQ_PERF_EN is defined and its absence otherwise.
module tb_rv32_barrel_mvu_jobq;
  localparam int NH = 8;
  localparam int NC = 26;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        hart_id;
  logic [11:0]       csr_addr;
  logic [2:0]        csr_op;
  logic [31:0]       csr_wdata;
  logic [31:0]       csr_rdata;
  logic              csr_illegal;
  logic [NH-1:0]     job_valid, job_ready, done, irq;
  logic [NH*NC*32-1:0] job_cfg;

  int          total = 0;
  int          passed = 0;
  logic        last_ill;
  logic [31:0] rv;

  rv32_barrel_mvu_jobq #(
    .NUM_HARTS (NH),
    .NUM_CFG   (NC),
    .QDEPTH    (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hart_id_i       (hart_id),
    .csr_addr_i      (csr_addr),
    .csr_op_i        (csr_op),
    .csr_wdata_i     (csr_wdata),
    .csr_rdata_o     (csr_rdata),
    .csr_illegal_o   (csr_illegal),
    .mvu_job_valid_o (job_valid),
    .mvu_job_ready_i (job_ready),
    .mvu_job_cfg_o   (job_cfg),
    .mvu_done_i      (done),
    .mvu_irq_o       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] word(input int h, input int i);
    return job_cfg[(h*NC+i)*32 +: 32];
  endfunction

  task automatic wr(input int h, input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    hart_id = h[2:0]; csr_op = op; csr_addr = a; csr_wdata = d;
    #1 last_ill = csr_illegal;
    @(posedge clk);
    #1 csr_op = 3'd0;
  endtask

  task automatic rd(input int h, input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    hart_id = h[2:0]; csr_op = 3'd4; csr_addr = a; csr_wdata = '0;
    #1 d = csr_rdata; last_ill = csr_illegal;
    csr_op = 3'd0;
  endtask

  task automatic pop(input int h);
    @(negedge clk); job_ready[h] = 1'b1;
    @(posedge clk); #1 job_ready[h] = 1'b0;
  endtask

  task automatic fin(input int h);
    @(negedge clk); done[h] = 1'b1;
    @(posedge clk); #1 done[h] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hart_id = '0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
    job_ready = '0; done = '0; last_ill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // reset state
    for (int h = 0; h < NH; h++) begin
      rd(h, 12'hF41, rv); chk($sformatf("rst_status_h%0d", h), rv, 32'h0);
    end
    chk("rst_valid", 32'(job_valid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // hart 3 single job
    wr(3, 3'd1, 12'hF20, 32'h1234);
    wr(3, 3'd1, 12'hF39, 32'hBEEF);
    wr(3, 3'd1, 12'hF40, 32'h1);
    chk("h3_valid", 32'(job_valid), 32'h08);
    chk("h3_word0", word(3, 0), 32'h1234);
    chk("h3_word25", word(3, 25), 32'hBEEF);
    pop(3);
    chk("h3_valid_after_pop", 32'(job_valid), 32'h0);
    rd(3, 12'hF41, rv); chk("h3_status_busy", rv, 32'h1);
    rd(3, 12'hF39, rv); chk("h3_staging_kept", rv, 32'hBEEF);
    fin(3);
    rd(3, 12'hF41, rv); chk("h3_status_done", rv, 32'h2);
    wr(3, 3'd1, 12'hF41, 32'h2);
    rd(3, 12'hF41, rv); chk("h3_status_w1c", rv, 32'h0);

    // hart 5 interrupt
    wr(5, 3'd1, 12'hF41, 32'h8);
    rd(5, 12'hF41, rv); chk("h5_irq_en", rv, 32'h8);
    wr(5, 3'd1, 12'hF40, 32'h1);
    pop(5);
    rd(5, 12'hF41, rv); chk("h5_busy", rv, 32'h9);
    @(negedge clk); done[5] = 1'b1;
    #1 chk("h5_irq_not_yet", 32'(irq), 32'h0);
    @(posedge clk); #1 done[5] = 1'b0;
    chk("h5_irq_rise", 32'(irq), 32'h20);
    wr(5, 3'd1, 12'hF41, 32'hA);
    chk("h5_irq_drop", 32'(irq), 32'h0);
    rd(5, 12'hF41, rv); chk("h5_irq_en_kept", rv, 32'h8);

    // hart 0 overflow and ordering
    wr(0, 3'd3, 12'hF40, 32'h1);
    rd(0, 12'hF41, rv); chk("h0_clear_cmd_noop", rv, 32'h0);
    wr(0, 3'd1, 12'hF20, 32'h1); wr(0, 3'd1, 12'hF40, 32'h1);
    wr(0, 3'd1, 12'hF20, 32'h2); wr(0, 3'd1, 12'hF40, 32'h1);
    wr(0, 3'd1, 12'hF20, 32'h3); wr(0, 3'd1, 12'hF40, 32'h1);
    rd(0, 12'hF41, rv); chk("h0_full_ovf", rv, 32'h204);
    chk("h0_first_word", word(0, 0), 32'h1);
    pop(0);
    rd(0, 12'hF41, rv); chk("h0_after_pop1", rv, 32'h105);
    fin(0);
    chk("h0_valid2", 32'(job_valid[0]), 32'h1);
    chk("h0_second_word", word(0, 0), 32'h2);
    pop(0); fin(0);
    rd(0, 12'hF41, rv); chk("h0_drained", rv, 32'h6);
    chk("h0_third_lost", 32'(job_valid[0]), 32'h0);
    wr(0, 3'd2, 12'hF41, 32'h4);
    rd(0, 12'hF41, rv); chk("h0_set_w1c_ovf", rv, 32'h2);
    wr(0, 3'd3, 12'hF41, 32'h2);
    rd(0, 12'hF41, rv); chk("h0_clear_noop", rv, 32'h2);
    wr(0, 3'd1, 12'hF41, 32'h2);

    // hart 2 simultaneous push and pop
    wr(2, 3'd1, 12'hF20, 32'hA);
    wr(2, 3'd1, 12'hF40, 32'h1);
    wr(2, 3'd1, 12'hF20, 32'hB);
    @(negedge clk);
    hart_id = 3'd2; csr_op = 3'd1; csr_addr = 12'hF40; csr_wdata = 32'h1; job_ready[2] = 1'b1;
    @(posedge clk); #1 csr_op = 3'd0; job_ready[2] = 1'b0;
    rd(2, 12'hF41, rv); chk("h2_pushpop_status", rv, 32'h101);
    chk("h2_head_next", word(2, 0), 32'hB);
    wr(2, 3'd2, 12'hF20, 32'h100);
    rd(2, 12'hF20, rv); chk("h2_cfg_set", rv, 32'h10B);
    wr(2, 3'd3, 12'hF20, 32'h3);
    rd(2, 12'hF20, rv); chk("h2_cfg_clear", rv, 32'h108);

    // per-hart isolation
    wr(1, 3'd1, 12'hF25, 32'h1111);
    wr(4, 3'd1, 12'hF25, 32'h4444);
    rd(1, 12'hF25, rv); chk("h1_isolated", rv, 32'h1111);
    rd(4, 12'hF25, rv); chk("h4_written", rv, 32'h4444);

    // illegal accesses
    wr(6, 3'd1, 12'hF41, 32'h9);
    chk("h6_ro_write_illegal", 32'(last_ill), 32'h1);
    rd(6, 12'hF41, rv); chk("h6_legal_field_applied", rv, 32'h8);
    chk("h6_read_legal", 32'(last_ill), 32'h0);
    rd(6, 12'hF3A, rv); chk("unmapped_rdata", rv, 32'h0);
    chk("unmapped_illegal", 32'(last_ill), 32'h1);
    rd(6, 12'h300, rv); chk("foreign_rdata", rv, 32'h0);
    chk("foreign_no_illegal", 32'(last_ill), 32'h0);
    rd(6, 12'hF40, rv); chk("cmd_read_zero", rv, 32'h0);
    chk("cmd_read_legal", 32'(last_ill), 32'h0);

    // busy-cycle counter, hart 7 busy for exactly 10 cycles
    wr(7, 3'd1, 12'hF40, 32'h1);
    pop(7);
    repeat (9) @(posedge clk);
    fin(7);
    rd(7, 12'hF41, rv); chk("h7_done", rv, 32'h2);
`ifdef MVU_JOBQ_PERF_EN
    rd(7, 12'hF42, rv); chk("perf_count", rv, 32'd10);
    chk("perf_legal", 32'(last_ill), 32'h0);
    wr(7, 3'd1, 12'hF42, 32'h123);
    rd(7, 12'hF42, rv); chk("perf_cleared", rv, 32'h0);
`else
    rd(7, 12'hF42, rv); chk("perf_absent_rdata", rv, 32'h0);
    chk("perf_absent_illegal", 32'(last_ill), 32'h1);
`endif

    // reset mid-job
    wr(0, 3'd1, 12'hF40, 32'h1);
    chk("pre_reset_valid", 32'(job_valid), 32'h01);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 chk("reset_valid_drop", 32'(job_valid), 32'h0);
    @(negedge clk) rst = 1'b0;
    rd(2, 12'hF41, rv); chk("reset_h2_status", rv, 32'h0);
    rd(0, 12'hF41, rv); chk("reset_h0_status", rv, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
